rfdc_dds_timed_sequencer: RTL and testbench

//  Timed command scheduler in front of the 16-lane RFDC DDS datapath.

---
 rtl/rfdc_dds_pkg.sv | 24 ++
 rtl/rfdc_dds_timed_sequencer_fifo.sv | 55 +++++
 rtl/rfdc_dds_timed_sequencer.sv | 124 ++++++++++++
 tb/tb_rfdc_dds_timed_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rfdc_dds_pkg.sv
// Shared types for the RFDC DDS timed sequencer: command layout, FSM states, widths.
package rfdc_dds_pkg;

  localparam int CMD_W                = 160;
  localparam int SAMPLES_PER_CLK_LOG2 = 4;

  // Field order (MSB first) matches the s_axis_tdata bit map.
  typedef struct packed {
    logic [4:0]  rsvd;
    logic        phase_rst;
    logic [13:0] amp_offset;
    logic [13:0] phase;
    logic [13:0] amp;
    logic [47:0] freq;
    logic [63:0] ts;
  } dds_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/rfdc_dds_timed_sequencer_fifo.sv
// First-word-fall-through command FIFO; dout shows the oldest entry whenever !empty.
module dds_cmd_fifo
  import rfdc_dds_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = CMD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // A push while full is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/rfdc_dds_timed_sequencer.sv
// Timed command scheduler: applies queued DDS parameter updates when their timestamp meets the local time counter.
module rfdc_dds_timed_sequencer
  import rfdc_dds_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     counter_clr,
  input  logic [159:0]             s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [47:0]              dds_freq,
  output logic [13:0]              dds_amp,
  output logic [13:0]              dds_phase,
  output logic [13:0]              dds_amp_offset,
  output logic [63:0]              dds_timestamp,
  output logic [63:0]              dds_time_offset,
  output logic                     fire_pulse,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     late_err,
  output logic                     ovf_err,
  input  logic                     err_clr,
  output logic [1:0]               dbg_state
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]  time_cnt, fire_cnt;
  seq_state_t       state, state_nxt;
  logic [CMD_W-1:0] head_raw;
  dds_cmd_t         head;
  logic             full, empty, push, pop;
  logic             fire_now, late_now, more;
  logic             unused_bits;

  // Handshake: a beat transfers on the rising edge where s_axis_tvalid && s_axis_tready;
  // tready is !full from the registered FIFO count, never from tvalid.
  assign s_axis_tready = !full;
  assign push          = s_axis_tvalid && !full;
  assign pop           = (state == FIRE);
  assign head          = dds_cmd_t'(head_raw);

  dds_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (s_axis_tdata),
    .pop   (pop),
    .dout  (head_raw),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              time_cnt <= '0;
    else if (counter_clr) time_cnt <= '0;
    else if (run)         time_cnt <= time_cnt + TS_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Parameters load on the ARMED->FIRE edge, so they appear one clk after time_cnt==ts.
  always_comb begin
    state_nxt = state;
    fire_now  = 1'b0;
    late_now  = 1'b0;
    more      = (fifo_level > LW'(1)) || push;
    case (state)
      IDLE:  if (run && !empty) state_nxt = ARMED;
      ARMED: begin
        if (!run) begin
          state_nxt = IDLE;
        end else if (head.ts <= time_cnt) begin
          fire_now  = 1'b1;
          late_now  = (head.ts < time_cnt);
          state_nxt = FIRE;
        end
      end
      FIRE:    state_nxt = more ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dds_freq       <= '0;
      dds_amp        <= '0;
      dds_phase      <= '0;
      dds_amp_offset <= '0;
      fire_cnt       <= '0;
    end else if (fire_now) begin
      dds_freq       <= head.freq;
      dds_amp        <= head.amp;
      dds_phase      <= head.phase;
      dds_amp_offset <= head.amp_offset;
      if (head.phase_rst) fire_cnt <= time_cnt;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      late_err <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      late_err <= late_now | (late_err & !err_clr);
      ovf_err  <= (s_axis_tvalid && full) | (ovf_err & !err_clr);
    end
  end

  assign fire_pulse      = (state == FIRE);
  assign dbg_state       = state;
  assign dds_timestamp   = {time_cnt[TS_W-SAMPLES_PER_CLK_LOG2-1:0], {SAMPLES_PER_CLK_LOG2{1'b0}}};
  assign dds_time_offset = {fire_cnt[TS_W-SAMPLES_PER_CLK_LOG2-1:0], {SAMPLES_PER_CLK_LOG2{1'b0}}};
  assign unused_bits     = ^{head.rsvd, fire_cnt[TS_W-1:TS_W-SAMPLES_PER_CLK_LOG2]};

endmodule

// File: tb/tb_rfdc_dds_timed_sequencer.sv
// Directed scenario bench for rfdc_dds_timed_sequencer with a cycle-accurate time model.
module tb_rfdc_dds_timed_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         run;
  logic         counter_clr;
  logic [159:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [47:0]  dds_freq;
  logic [13:0]  dds_amp;
  logic [13:0]  dds_phase;
  logic [13:0]  dds_amp_offset;
  logic [63:0]  dds_timestamp;
  logic [63:0]  dds_time_offset;
  logic         fire_pulse;
  logic [4:0]   fifo_level;
  logic         late_err;
  logic         ovf_err;
  logic         err_clr;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  int tnow   = 0;

  rfdc_dds_timed_sequencer #(.DEPTH(16), .TS_W(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .counter_clr     (counter_clr),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .dds_freq        (dds_freq),
    .dds_amp         (dds_amp),
    .dds_phase       (dds_phase),
    .dds_amp_offset  (dds_amp_offset),
    .dds_timestamp   (dds_timestamp),
    .dds_time_offset (dds_time_offset),
    .fire_pulse      (fire_pulse),
    .fifo_level      (fifo_level),
    .late_err        (late_err),
    .ovf_err         (ovf_err),
    .err_clr         (err_clr),
    .dbg_state       (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // Advance one clock, tracking the expected time counter, and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst)              tnow = 0;
    else if (counter_clr) tnow = 0;
    else if (run)         tnow = tnow + 1;
    #1;
  endtask

  function automatic logic [159:0] mk_cmd(input logic [63:0] ts, input logic [47:0] freq,
                                          input logic [13:0] amp, input logic [13:0] phase,
                                          input logic [13:0] aoff, input logic prst);
    return {5'b00000, prst, aoff, phase, amp, freq, ts};
  endfunction

  task automatic push_cmd(input logic [159:0] d);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_fire(input int budget, output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (fire_pulse) begin
        ok = 1'b1;
        t  = tnow;
        break;
      end
    end
  endtask

  task automatic clear_time();
    counter_clr = 1'b1;
    tick();
    counter_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; counter_clr = 1'b0; s_axis_tvalid = 1'b0;
    s_axis_tdata = '0; err_clr = 1'b0;
    tick(); tick();
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %0b want 1", s_axis_tready); end
    checks++; if ({dds_freq, dds_amp, dds_phase, dds_amp_offset} !== 90'd0) begin errors++; $display("FAIL reset_params got %0h want 0", {dds_freq, dds_amp, dds_phase, dds_amp_offset}); end
    checks++; if ({dds_timestamp, dds_time_offset} !== 128'd0) begin errors++; $display("FAIL reset_time got %0h want 0", {dds_timestamp, dds_time_offset}); end
    checks++; if ({fire_pulse, fifo_level, late_err, ovf_err, dbg_state} !== 10'd0) begin errors++; $display("FAIL reset_misc got %0h want 0", {fire_pulse, fifo_level, late_err, ovf_err, dbg_state}); end
    rst = 1'b0;
    tnow = 0;
  endtask

  task automatic test_single_fire();
    int t; bit ok; int extra;
    run = 1'b1;
    clear_time();
    push_cmd(mk_cmd(64'd100, 48'h1000_0000_0000, 14'h1FFF, 14'h0123, 14'h0042, 1'b0));
    wait_fire(200, t, ok);
    checks++; if (!ok || t != 101) begin errors++; $display("FAIL single_fire_time got %0d want 101", t); end
    checks++; if (dds_freq !== 48'h1000_0000_0000) begin errors++; $display("FAIL single_freq got %0h want 100000000000", dds_freq); end
    checks++; if (dds_amp !== 14'h1FFF) begin errors++; $display("FAIL single_amp got %0h want 1fff", dds_amp); end
    checks++; if ({dds_phase, dds_amp_offset} !== {14'h0123, 14'h0042}) begin errors++; $display("FAIL single_phase_aoff got %0h want %0h", {dds_phase, dds_amp_offset}, {14'h0123, 14'h0042}); end
    checks++; if (dds_timestamp !== 64'd1616) begin errors++; $display("FAIL single_timestamp got %0d want 1616", dds_timestamp); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fire_pulse) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL single_pulse_count got %0d extra want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int t; bit ok;
    int exp_t [3] = '{51, 61, 71};
    clear_time();
    push_cmd(mk_cmd(64'd50, 48'd11, 14'd1, 14'd0, 14'd0, 1'b0));
    push_cmd(mk_cmd(64'd60, 48'd22, 14'd2, 14'd0, 14'd0, 1'b0));
    push_cmd(mk_cmd(64'd70, 48'd33, 14'd3, 14'd0, 14'd0, 1'b0));
    checks++; if (fifo_level !== 5'd3) begin errors++; $display("FAIL b2b_level3 got %0d want 3", fifo_level); end
    for (int i = 0; i < 3; i++) begin
      wait_fire(100, t, ok);
      checks++; if (!ok || t != exp_t[i]) begin errors++; $display("FAIL b2b_fire%0d got %0d want %0d", i, t, exp_t[i]); end
      checks++; if (dds_freq !== 48'(11 * (i + 1))) begin errors++; $display("FAIL b2b_freq%0d got %0d want %0d", i, dds_freq, 11 * (i + 1)); end
    end
    tick();
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL b2b_level0 got %0d want 0", fifo_level); end
    checks++; if (late_err !== 1'b0) begin errors++; $display("FAIL b2b_late got %0b want 0", late_err); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL b2b_idle got %0d want 0", dbg_state); end
  endtask

  task automatic test_late();
    int t; bit ok;
    clear_time();
    repeat (200) tick();
    push_cmd(mk_cmd(64'd10, 48'h00AB_CDEF, 14'd7, 14'd0, 14'd0, 1'b0));
    wait_fire(10, t, ok);
    checks++; if (!ok || t > 203) begin errors++; $display("FAIL late_fire_time got %0d want <=203", t); end
    checks++; if (late_err !== 1'b1) begin errors++; $display("FAIL late_err_set got %0b want 1", late_err); end
    checks++; if (dds_freq !== 48'h00AB_CDEF) begin errors++; $display("FAIL late_freq got %0h want abcdef", dds_freq); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (late_err !== 1'b0) begin errors++; $display("FAIL late_err_clr got %0b want 0", late_err); end
  endtask

  task automatic test_overflow();
    int t; bit ok;
    run = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) begin
      s_axis_tdata  = mk_cmd(64'(1000 + 4 * i), 48'(i + 1), 14'd0, 14'd0, 14'd0, 1'b0);
      s_axis_tvalid = 1'b1;
      checks++; if (s_axis_tready !== (i < 16)) begin errors++; $display("FAIL ovf_tready%0d got %0b want %0b", i, s_axis_tready, (i < 16)); end
      tick();
    end
    s_axis_tvalid = 1'b0;
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", fifo_level); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_err_set got %0b want 1", ovf_err); end
    s_axis_tvalid = 1'b1; err_clr = 1'b1;
    tick();
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0b want 1", ovf_err); end
    s_axis_tvalid = 1'b0;
    tick();
    err_clr = 1'b0;
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_err_clr got %0b want 0", ovf_err); end
    run = 1'b1;
    clear_time();
    for (int i = 0; i < 16; i++) begin
      wait_fire(1100, t, ok);
      checks++; if (!ok || t != 1001 + 4 * i || dds_freq !== 48'(i + 1)) begin errors++; $display("FAIL drain%0d got t=%0d freq=%0d want t=%0d freq=%0d", i, t, dds_freq, 1001 + 4 * i, i + 1); end
    end
    wait_fire(100, t, ok);
    checks++; if (ok) begin errors++; $display("FAIL ovf_dropped got fire at %0d want none", t); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL ovf_drained got %0d want 0", fifo_level); end
  endtask

  task automatic test_phase_rst();
    int t; bit ok;
    clear_time();
    push_cmd(mk_cmd(64'd300, 48'd300, 14'd5, 14'd9, 14'd0, 1'b1));
    push_cmd(mk_cmd(64'd320, 48'd320, 14'd6, 14'd9, 14'd0, 1'b0));
    wait_fire(400, t, ok);
    checks++; if (!ok || t != 301) begin errors++; $display("FAIL prst_fire_time got %0d want 301", t); end
    checks++; if (dds_time_offset !== 64'd4800) begin errors++; $display("FAIL prst_offset got %0d want 4800", dds_time_offset); end
    wait_fire(100, t, ok);
    checks++; if (!ok || t != 321 || dds_freq !== 48'd320) begin errors++; $display("FAIL prst_second got t=%0d freq=%0d want t=321 freq=320", t, dds_freq); end
    checks++; if (dds_time_offset !== 64'd4800) begin errors++; $display("FAIL prst_held got %0d want 4800", dds_time_offset); end
  endtask

  task automatic test_reset_and_clear();
    int t; bit ok;
    for (int i = 0; i < 4; i++) push_cmd(mk_cmd(64'(5000 + i), 48'(77 + i), 14'd1, 14'd1, 14'd1, 1'b0));
    checks++; if (dbg_state !== 2'd1 || fifo_level !== 5'd4) begin errors++; $display("FAIL pre_rst got state=%0d level=%0d want 1/4", dbg_state, fifo_level); end
    rst = 1'b1;
    #1;
    checks++; if ({dds_freq, dds_amp, dds_phase, dds_amp_offset, dds_time_offset} !== '0) begin errors++; $display("FAIL async_rst_params got %0h want 0", {dds_freq, dds_amp, dds_phase, dds_amp_offset, dds_time_offset}); end
    checks++; if (s_axis_tready !== 1'b1 || fifo_level !== 5'd0 || dbg_state !== 2'd0) begin errors++; $display("FAIL async_rst_fifo got tready=%0b level=%0d state=%0d want 1/0/0", s_axis_tready, fifo_level, dbg_state); end
    rst = 1'b0;
    tnow = 0;
    push_cmd(mk_cmd(64'd5, 48'h5555, 14'd2, 14'd3, 14'd4, 1'b0));
    repeat (3) tick();
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL clr_armed got %0d want 1", dbg_state); end
    clear_time();
    wait_fire(50, t, ok);
    checks++; if (!ok || t != 6) begin errors++; $display("FAIL clr_fire_time got %0d want 6", t); end
    checks++; if (dds_timestamp !== 64'd96 || dds_freq !== 48'h5555) begin errors++; $display("FAIL clr_fire_vals got ts=%0d freq=%0h want 96/5555", dds_timestamp, dds_freq); end
    checks++; if (late_err !== 1'b0) begin errors++; $display("FAIL clr_late got %0b want 0", late_err); end
  endtask

  initial begin
    test_reset();
    test_single_fire();
    test_back_to_back();
    test_late();
    test_overflow();
    test_phase_rst();
    test_reset_and_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
